// File: rtl/hex_display_bank_if.sv
// Purpose: bundles the load-side inputs and display-side outputs of hex_display_bank.
// Latency: none, this is wiring only.
// Backpressure: none; load is a plain strobe and the display side is free-running.
// Ports: master drives load/value/dp_in/blank_mask/blink_mask/blink_en and reads
//        segments/blink_phase; slave is the opposite direction.
interface hex_display_bank_if #(
  parameter int DIGITS = 6
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_mask;
  logic [DIGITS-1:0]     blink_mask;
  logic                  blink_en;
  logic [8*DIGITS-1:0]   segments;
  logic                  blink_phase;

  modport master (
    output load, value, dp_in, blank_mask, blink_mask, blink_en,
    input  segments, blink_phase
  );

  modport slave (
    input  load, value, dp_in, blank_mask, blink_mask, blink_en,
    output segments, blink_phase
  );
endinterface

// File: rtl/hex_display_bank.sv
// Purpose: bank of DIGITS seven-segment hex decoders with latch, blanking and blinking.
// Latency: load-to-pin 2 edges (latch, then registered segments); blink phase 1 edge to pin.
// Backpressure: none; load is accepted every cycle it is high.
// Ports: clk, resetN (synchronous, active-low), bus (hex_display_bank_if.slave):
//        load/value/dp_in/blank_mask/blink_mask/blink_en in, segments/blink_phase out.
// Option: define LEADING_ZERO_BLANK_EN to glyph-blank leading zero digits.
module hex_display_bank #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               resetN,
  hex_display_bank_if.slave  bus
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  // Active-high g..a glyph for one hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   blink_mask_q, blink_mask_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [8*DIGITS-1:0] seg_q, seg_d;
  logic [DIGITS-1:0]   lz;
`ifdef LEADING_ZERO_BLANK_EN
  logic                lead;
`endif

  // Input latch.
  always_comb begin
    value_d      = value_q;
    dp_d         = dp_q;
    blank_d      = blank_q;
    blink_mask_d = blink_mask_q;
    if (bus.load) begin
      value_d      = bus.value;
      dp_d         = bus.dp_in;
      blank_d      = bus.blank_mask;
      blink_mask_d = bus.blink_mask;
    end
  end

  // Blink timer: disabling it parks the phase in the visible state.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!bus.blink_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Leading-zero mask: a digit is suppressed while every nibble above it
  // (and itself) is zero. Digit 0 always shows its glyph.
  always_comb begin
    lz = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (value_q[4*i +: 4] != 4'h0) lead = 1'b0;
      lz[i] = lead;
    end
`endif
  end

  // Segment decode from latched state and the current phase; registered below.
  always_comb begin
    seg_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (blank_q[i]) begin
        seg_d[8*i +: 8] = 8'hFF;
      end else if (blink_mask_q[i] && phase_q) begin
        seg_d[8*i +: 8] = 8'hFF;
      end else if (lz[i]) begin
        seg_d[8*i +: 8] = {~dp_q[i], 7'h7F};
      end else begin
        seg_d[8*i +: 8] = ~{dp_q[i], glyph(value_q[4*i +: 4])};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      value_q      <= '0;
      dp_q         <= '0;
      blank_q      <= '1;
      blink_mask_q <= '0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      seg_q        <= '1;
    end else begin
      value_q      <= value_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      blink_mask_q <= blink_mask_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.segments    = seg_q;
  assign bus.blink_phase = phase_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Purpose: directed self-checking bench for hex_display_bank (DIGITS=6, BLINK_DIV=4).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none exercised; load is a strobe.
module tb_hex_display_bank;

  logic clk = 1'b0;
  logic resetN;
  int   npass  = 0;
  int   ntotal = 0;

  always #5 clk = ~clk;

  hex_display_bank_if #(.DIGITS(6)) bus ();

  hex_display_bank #(
    .DIGITS    (6),
    .BLINK_DIV (4)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [47:0] EXP_50     = 48'hFFFF_FFFF_92C0;
  localparam logic [47:0] EXP_50_DP3 = 48'hFFFF_7FFF_92C0;
  localparam logic [47:0] EXP_00     = 48'hFFFF_FFFF_FFC0;
  localparam logic [47:0] EXP_05     = 48'hFFFF_FFFF_FF92;
  localparam logic [47:0] EXP_05_OFF = 48'hFFFF_FFFF_FFFF;
`else
  localparam logic [47:0] EXP_50     = 48'hC0C0_C0C0_92C0;
  localparam logic [47:0] EXP_50_DP3 = 48'hC0C0_40C0_92C0;
  localparam logic [47:0] EXP_00     = 48'hC0C0_C0C0_C0C0;
  localparam logic [47:0] EXP_05     = 48'hC0C0_C0C0_C092;
  localparam logic [47:0] EXP_05_OFF = 48'hC0C0_C0C0_C0FF;
`endif
  localparam logic [47:0] ALL_DARK   = 48'hFFFF_FFFF_FFFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_in(input logic [23:0] v, input logic [5:0] dp,
                        input logic [5:0] blank, input logic [5:0] bmask);
    bus.value      = v;
    bus.dp_in      = dp;
    bus.blank_mask = blank;
    bus.blink_mask = bmask;
  endtask

  initial begin
    resetN     = 1'b0;
    bus.load   = 1'b0;
    bus.blink_en = 1'b0;
    set_in(24'h0, 6'h0, 6'h0, 6'h0);

    // Reset state, then idle without load.
    tick(); tick();
    check("reset_seg", bus.segments, ALL_DARK);
    check("reset_phase", {47'd0, bus.blink_phase}, 48'd0);
    resetN = 1'b1;
    tick();
    check("idle_seg", bus.segments, ALL_DARK);

    // Basic decode with 2-edge latency.
    set_in(24'h12AB3F, 6'h0, 6'h0, 6'h0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("lat_e0", bus.segments, ALL_DARK);
    tick();
    check("decode_12AB3F", bus.segments, 48'hF9A4_8883_B08E);

    // Zero handling (leading-zero option dependent).
    set_in(24'h000050, 6'h0, 6'h0, 6'h0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    check("zeros_50", bus.segments, EXP_50);

    set_in(24'h000050, 6'b001000, 6'h0, 6'h0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    check("zeros_50_dp3", bus.segments, EXP_50_DP3);

    set_in(24'h000000, 6'h0, 6'h0, 6'h0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    check("all_zero", bus.segments, EXP_00);

    // Blink on digit 0; phase toggles every 4 edges, display lags phase by one edge.
    set_in(24'h000005, 6'h0, 6'h0, 6'b000001);
    bus.load     = 1'b1;
    bus.blink_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      bus.load = 1'b0;
      check($sformatf("blink_phase_%0d", k), {47'd0, bus.blink_phase},
            {47'd0, 1'((k / 4) % 2)});
      if (k == 1)
        check("blink_seg_1", bus.segments, EXP_00);
      else
        check($sformatf("blink_seg_%0d", k), bus.segments,
              (((k - 1) / 4) % 2 == 1) ? EXP_05_OFF : EXP_05);
    end

    // Drop blink_en while dark: phase clears at once, digit returns one edge later.
    bus.blink_en = 1'b0;
    tick();
    check("blink_off_phase", {47'd0, bus.blink_phase}, 48'd0);
    check("blink_off_seg1", bus.segments, EXP_05_OFF);
    tick();
    check("blink_off_seg2", bus.segments, EXP_05);

    // Blank beats the decimal point.
    set_in(24'h800005, 6'b100000, 6'b100000, 6'h0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    check("blank_dp5", bus.segments, 48'hFFC0_C0C0_C092);

    // Load on the same edge as a blink wrap.
    bus.blink_en = 1'b1;
    tick(); tick(); tick();
    set_in(24'h700007, 6'h0, 6'h0, 6'b000001);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("wrap_phase", {47'd0, bus.blink_phase}, 48'd1);
    check("wrap_old_seg", bus.segments, 48'hFFC0_C0C0_C092);
    tick();
    check("wrap_new_seg", bus.segments, 48'hF8C0_C0C0_C0FF);

    // One-cycle reset pulse mid-blink; load during reset is ignored.
    resetN   = 1'b0;
    bus.load = 1'b1;
    set_in(24'h123456, 6'h0, 6'h0, 6'h0);
    tick();
    check("rst_pulse_seg", bus.segments, ALL_DARK);
    check("rst_pulse_phase", {47'd0, bus.blink_phase}, 48'd0);
    resetN = 1'b1;
    set_in(24'h000005, 6'h0, 6'h0, 6'b000001);
    tick();
    bus.load = 1'b0;
    check("post_rst_e0", bus.segments, ALL_DARK);
    tick();
    check("post_rst_load", bus.segments, EXP_05);
    tick();
    check("post_rst_phase3", {47'd0, bus.blink_phase}, 48'd0);
    tick();
    check("post_rst_phase4", {47'd0, bus.blink_phase}, 48'd1);
    tick();
    check("post_rst_dark", bus.segments, EXP_05_OFF);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
